emergency_preempt: RTL and testbench
====================================

EMERGENCY_PREEMPT -- requirements
Module: emergency_preempt

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4: consecutive synchronized-request cycles needed to qualify (range 1-255).
REQ-002 Parameter HOLD_CYC, default 20: minimum cycles emergency stays high after all-red is confirmed (range 1-255).
REQ-003 Parameter COOLDOWN_CYC, default 10: cycles requests are ignored after release (range 1-255).
REQ-004 Parameter WDOG_CYC, default 64: all-red wait limit, used only with EV_WATCHDOG_EN (range 1-255).
REQ-005 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 Port rst  input  1  asynchronous, active-low reset.
REQ-007 Port ev_ns  input  1  raw, asynchronous NS emergency-vehicle sensor.
REQ-008 Port ev_ew  input  1  raw, asynchronous EW emergency-vehicle sensor.
REQ-009 Port all_red  input  1  from the light controller: Red_NS & Red_EW.
REQ-010 Port emergency  output  1  preemption request to the light controller; registered.
REQ-011 Port grant_ns  output  1  NS beacon; high in HOLD when NS is the latched direction.
REQ-012 Port grant_ew  output  1  EW beacon; high in HOLD when EW is the latched direction.
REQ-013 Port preempt_cnt  output  8  saturating count of PREEMPT entries.
REQ-014 Port fault  output  1  sticky watchdog fault flag.

Function
REQ-015 ev_ns and ev_ew SHALL each pass through a two-flop synchronizer; the FSM sees only the synchronized values (ns_s, ew_s).
REQ-016 The FSM SHALL have the states IDLE, QUALIFY, PREEMPT, HOLD and COOLDOWN; all outputs are registered.
REQ-017 IDLE: when ns_s|ew_s = 1, go to QUALIFY; latch the direction, with NS winning if both are high.
REQ-018 QUALIFY: count consecutive cycles in which the latched direction's sync signal is high; if it drops, return to IDLE and clear the count; on reaching DEBOUNCE_CYC, go to PREEMPT.
REQ-019 Latency: if the first rising edge that samples a raw input high is edge 0 and the input stays high, emergency SHALL be 1 after edge 1+DEBOUNCE_CYC.
REQ-020 PREEMPT: emergency = 1; preempt_cnt increments by 1 on entry and saturates at 255; go to HOLD on the first cycle with all_red = 1.
REQ-021 HOLD: emergency = 1 and the grant for the latched direction = 1; the hold counter counts HOLD_CYC cycles; leave for COOLDOWN only once the counter has expired and the latched sync request = 0, otherwise stay in HOLD.
REQ-022 all_red falling during HOLD SHALL have no effect on the FSM.
REQ-023 COOLDOWN: emergency = 0 and grants = 0; requests are ignored for COOLDOWN_CYC cycles, then go to IDLE.
REQ-024 The opposite direction requesting during PREEMPT or HOLD SHALL NOT change the latched direction; it is served after COOLDOWN if it is still asserted.
REQ-025 grant_ns and grant_ew SHALL never both be 1.

Reset
REQ-026 rst = 0 SHALL immediately force IDLE and clear the synchronizers, all counters, emergency, grants, preempt_cnt and fault, including in the middle of a preemption.
REQ-027 After rst rises, the first FSM transition SHALL occur no earlier than the second rising edge.

Configuration
REQ-028 Macro EV_WATCHDOG_EN defined: if PREEMPT lasts WDOG_CYC cycles without all_red, fault becomes 1 (sticky until reset) and the FSM goes to COOLDOWN.
REQ-029 EV_WATCHDOG_EN undefined: PREEMPT waits for all_red indefinitely and fault is tied to 0.

Verification
REQ-030 Defaults; ev_ns high from edge 0 and all_red high from edge 8 -> emergency = 1 after edge 5; grant_ns = 1 from edge 9; preempt_cnt = 1.
REQ-031 Defaults; ev_ew pulses high for 3 cycles -> emergency stays 0 and the FSM returns to IDLE.
REQ-032 Defaults; ev_ns and ev_ew rise together, ev_ns held 40 cycles -> grant_ns only; emergency falls on the first HOLD exit condition; EW is served after the 10-cycle cooldown.
REQ-033 EV_WATCHDOG_EN defined; request held with all_red = 0 -> fault = 1 and emergency = 0 exactly 64 cycles after PREEMPT entry; fault stays 1 until reset.
REQ-034 rst pulsed low during HOLD -> all outputs 0 asynchronously, before the next clock edge.
REQ-035 300 qualified preemptions -> preempt_cnt = 255.

Source files
------------

// File: rtl/emergency_preempt.sv
// Emergency-vehicle preemption controller: synchronizes NS/EW sensors, debounces, requests all-red and holds beacons.
// Optional build macro EV_WATCHDOG_EN: faults and releases when all-red never arrives within WDOG_CYC cycles.
module emergency_preempt #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned HOLD_CYC     = 20,
  parameter int unsigned COOLDOWN_CYC = 10,
  parameter int unsigned WDOG_CYC     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ev_ns,
  input  logic       ev_ew,
  input  logic       all_red,
  output logic       emergency,
  output logic       grant_ns,
  output logic       grant_ew,
  output logic [7:0] preempt_cnt,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_QUALIFY  = 3'd1,
    S_PREEMPT  = 3'd2,
    S_HOLD     = 3'd3,
    S_COOLDOWN = 3'd4
  } state_t;

  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYC - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
  localparam logic [7:0] CD_LAST   = 8'(COOLDOWN_CYC - 1);

  state_t     state_q, state_d;
  logic [1:0] ns_sync_q, ew_sync_q;
  logic       dir_ew_q, dir_ew_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] preempt_cnt_q, preempt_cnt_d;
  logic       emergency_q, emergency_d;
  logic       grant_ns_q, grant_ns_d;
  logic       grant_ew_q, grant_ew_d;
  logic       fault_q, fault_d;
  logic       ns_s, ew_s, req_s;

  assign ns_s  = ns_sync_q[1];
  assign ew_s  = ew_sync_q[1];
  assign req_s = dir_ew_q ? ew_s : ns_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ns_sync_q <= '0;
      ew_sync_q <= '0;
    end else begin
      ns_sync_q <= {ns_sync_q[0], ev_ns};
      ew_sync_q <= {ew_sync_q[0], ev_ew};
    end
  end

  always_comb begin
    state_d       = state_q;
    dir_ew_d      = dir_ew_q;
    preempt_cnt_d = preempt_cnt_q;
    fault_d       = fault_q;
    case (state_q)
      S_IDLE: begin
        if (ns_s || ew_s) begin
          dir_ew_d = !ns_s;
          state_d  = (DEBOUNCE_CYC <= 1) ? S_PREEMPT : S_QUALIFY;
        end
      end
      S_QUALIFY: begin
        if (!req_s)                 state_d = S_IDLE;
        else if (cnt_q >= DEB_LAST) state_d = S_PREEMPT;
      end
      S_PREEMPT: begin
        if (all_red) state_d = S_HOLD;
`ifdef EV_WATCHDOG_EN
        else if (cnt_q >= 8'(WDOG_CYC - 1)) begin
          state_d = S_COOLDOWN;
          fault_d = 1'b1;
        end
`endif
      end
      S_HOLD: begin
        if (cnt_q >= HOLD_LAST && !req_s) state_d = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (cnt_q >= CD_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // One shared counter: restarts on every state change; QUALIFY entry already counts its first cycle.
    if (state_d != state_q) cnt_d = (state_d == S_QUALIFY) ? 8'd1 : '0;
    else                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 8'd1;

    if (state_d == S_PREEMPT && state_q != S_PREEMPT && preempt_cnt_q != '1)
      preempt_cnt_d = preempt_cnt_q + 8'd1;

    emergency_d = (state_d == S_PREEMPT) || (state_d == S_HOLD);
    grant_ns_d  = (state_d == S_HOLD) && !dir_ew_d;
    grant_ew_d  = (state_d == S_HOLD) && dir_ew_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      dir_ew_q      <= 1'b0;
      cnt_q         <= '0;
      preempt_cnt_q <= '0;
      emergency_q   <= 1'b0;
      grant_ns_q    <= 1'b0;
      grant_ew_q    <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_ew_q      <= dir_ew_d;
      cnt_q         <= cnt_d;
      preempt_cnt_q <= preempt_cnt_d;
      emergency_q   <= emergency_d;
      grant_ns_q    <= grant_ns_d;
      grant_ew_q    <= grant_ew_d;
      fault_q       <= fault_d;
    end
  end

  assign emergency   = emergency_q;
  assign grant_ns    = grant_ns_q;
  assign grant_ew    = grant_ew_q;
  assign preempt_cnt = preempt_cnt_q;
`ifdef EV_WATCHDOG_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_emergency_preempt.sv
// Directed self-checking bench for emergency_preempt at default parameters.
module tb_emergency_preempt;

  logic       clk, rst, ev_ns, ev_ew, all_red;
  logic       emergency, grant_ns, grant_ew, fault;
  logic [7:0] preempt_cnt;
  int         checks = 0;
  int         passed = 0;

  emergency_preempt #(
    .DEBOUNCE_CYC(4),
    .HOLD_CYC    (20),
    .COOLDOWN_CYC(10),
    .WDOG_CYC    (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ev_ns      (ev_ns),
    .ev_ew      (ev_ew),
    .all_red    (all_red),
    .emergency  (emergency),
    .grant_ns   (grant_ns),
    .grant_ew   (grant_ew),
    .preempt_cnt(preempt_cnt),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; ev_ns = 1'b0; ev_ew = 1'b0; all_red = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; ev_ns = 1'b1; ev_ew = 1'b1; all_red = 1'b1;
    repeat (3) tick();
    checks++; if (emergency !== 1'b0) $display("FAIL reset_emergency: got %b want 0", emergency); else passed++;
    checks++; if ({grant_ns, grant_ew} !== 2'b00) $display("FAIL reset_grants: got %b want 00", {grant_ns, grant_ew}); else passed++;
    checks++; if (preempt_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", preempt_cnt); else passed++;
    checks++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else passed++;
  endtask

  task automatic test_latency();
    do_reset();
    ev_ns = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick();
      if (e == 4) begin
        checks++; if (emergency !== 1'b0) $display("FAIL lat_early: edge 4 got %b want 0", emergency); else passed++;
      end
      if (e == 5) begin
        checks++; if (emergency !== 1'b1) $display("FAIL lat_emerg: edge 5 got %b want 1", emergency); else passed++;
        checks++; if (preempt_cnt !== 8'd1) $display("FAIL lat_cnt: got %0d want 1", preempt_cnt); else passed++;
      end
      if (e == 8) begin
        checks++; if (grant_ns !== 1'b0) $display("FAIL lat_grant_early: edge 8 got %b want 0", grant_ns); else passed++;
        all_red = 1'b1;
      end
      if (e == 9) begin
        checks++; if ({grant_ns, grant_ew} !== 2'b10) $display("FAIL lat_grant: edge 9 got %b want 10", {grant_ns, grant_ew}); else passed++;
      end
    end
  endtask

  task automatic test_short_pulse();
    logic seen;
    do_reset();
    all_red = 1'b1;
    ev_ew = 1'b1;
    repeat (3) tick();
    ev_ew = 1'b0;
    seen = 1'b0;
    repeat (12) begin tick(); seen |= emergency; end
    checks++; if (seen !== 1'b0) $display("FAIL pulse_emerg: got %b want 0", seen); else passed++;
    ev_ns = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick();
      if (e == 4) begin
        checks++; if (emergency !== 1'b0) $display("FAIL pulse_idle_early: got %b want 0", emergency); else passed++;
      end
      if (e == 5) begin
        checks++; if (emergency !== 1'b1) $display("FAIL pulse_idle_lat: got %b want 1", emergency); else passed++;
      end
    end
  endtask

  task automatic test_both_dirs();
    logic both;
    do_reset();
    all_red = 1'b1;
    ev_ns = 1'b1; ev_ew = 1'b1;
    both = 1'b0;
    for (int e = 0; e <= 58; e++) begin
      tick();
      both |= grant_ns & grant_ew;
      if (e == 6) begin
        checks++; if ({grant_ns, grant_ew} !== 2'b10) $display("FAIL both_ns_grant: got %b want 10", {grant_ns, grant_ew}); else passed++;
      end
      if (e == 41) begin
        checks++; if (emergency !== 1'b1) $display("FAIL both_hold: edge 41 got %b want 1", emergency); else passed++;
      end
      if (e == 42) begin
        checks++; if (emergency !== 1'b0) $display("FAIL both_release: edge 42 got %b want 0", emergency); else passed++;
      end
      if (e == 55) begin
        checks++; if (emergency !== 1'b0) $display("FAIL both_cooldown: edge 55 got %b want 0", emergency); else passed++;
      end
      if (e == 56) begin
        checks++; if (emergency !== 1'b1) $display("FAIL both_ew_emerg: edge 56 got %b want 1", emergency); else passed++;
      end
      if (e == 57) begin
        checks++; if ({grant_ns, grant_ew} !== 2'b01) $display("FAIL both_ew_grant: got %b want 01", {grant_ns, grant_ew}); else passed++;
        checks++; if (preempt_cnt !== 8'd2) $display("FAIL both_cnt: got %0d want 2", preempt_cnt); else passed++;
      end
      if (e == 39) ev_ns = 1'b0;
    end
    checks++; if (both !== 1'b0) $display("FAIL both_exclusive: got %b want 0", both); else passed++;
  endtask

  task automatic test_watchdog();
    do_reset();
    all_red = 1'b0;
    ev_ns = 1'b1;
    for (int e = 0; e <= 120; e++) begin
      tick();
      if (e == 68) begin
        checks++; if ({emergency, fault} !== 2'b10) $display("FAIL wd_before: got %b want 10", {emergency, fault}); else passed++;
      end
      if (e == 69) begin
`ifdef EV_WATCHDOG_EN
        checks++; if ({emergency, fault} !== 2'b01) $display("FAIL wd_trip: got %b want 01", {emergency, fault}); else passed++;
`else
        checks++; if ({emergency, fault} !== 2'b10) $display("FAIL wd_wait: got %b want 10", {emergency, fault}); else passed++;
`endif
      end
      if (e == 120) begin
`ifdef EV_WATCHDOG_EN
        checks++; if (fault !== 1'b1) $display("FAIL wd_sticky: got %b want 1", fault); else passed++;
`else
        checks++; if ({emergency, fault} !== 2'b10) $display("FAIL wd_forever: got %b want 10", {emergency, fault}); else passed++;
`endif
      end
    end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    all_red = 1'b1;
    ev_ns = 1'b1;
    repeat (10) tick();
    checks++; if ({emergency, grant_ns} !== 2'b11) $display("FAIL rih_pre: got %b want 11", {emergency, grant_ns}); else passed++;
    rst = 1'b0;
    #1;
    checks++; if ({emergency, grant_ns, grant_ew, fault} !== 4'b0000) $display("FAIL rih_async: got %b want 0000", {emergency, grant_ns, grant_ew, fault}); else passed++;
    checks++; if (preempt_cnt !== 8'd0) $display("FAIL rih_cnt: got %0d want 0", preempt_cnt); else passed++;
    ev_ns = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    all_red = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      ev_ns = 1'b1;
      repeat (7) tick();
      ev_ns = 1'b0;
      repeat (40) tick();
      if (n == 1) begin
        checks++; if (preempt_cnt !== 8'd1) $display("FAIL sat_first: got %0d want 1", preempt_cnt); else passed++;
      end
      if (n == 255 || n == 256 || n == 300) begin
        checks++; if (preempt_cnt !== 8'd255) $display("FAIL sat_%0d: got %0d want 255", n, preempt_cnt); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_short_pulse();
    test_both_dirs();
    test_watchdog();
    test_reset_in_hold();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
